picorv_axi_master_bridge: RTL and testbench

Converts the PicoRV32 native memory interface (mem_valid/mem_ready) into an AXI4-Lite master. It sits directly upstream of the 64 KiB AXI4-Lite memory slave used in the Vivado simulation and FPGA flow. It handles one transaction at a time. Write address and write data channels complete independently, and a sticky timeout flag reports a hung slave.

---
 rtl/picorv_axi_master_bridge_pkg.sv | 21 ++
 rtl/picorv_axi_master_bridge.sv | 146 ++++++++++++++
 tb/tb_picorv_axi_master_bridge.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/picorv_axi_master_bridge_pkg.sv
// Shared types and constants for the PicoRV32-to-AXI4-Lite master bridge.
package picorv_axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WAIT_B,
      ST_RD,
      ST_WAIT_R,
      ST_RESP
   } state_e;

   localparam logic [2:0] AXI_PROT_DATA  = 3'b000;
   localparam logic [2:0] AXI_PROT_INSN  = 3'b100;
   localparam logic [3:0] MEM_WSTRB_READ = 4'b0000;

   function automatic logic [2:0] read_prot(input logic instr);
      return instr ? AXI_PROT_INSN : AXI_PROT_DATA;
   endfunction

endpackage

// File: rtl/picorv_axi_master_bridge.sv
// PicoRV32 native memory port to AXI4-Lite master, one transaction in flight,
// with a sticky timeout flag for a slave that never answers.
module picorv_axi_master_bridge
   import picorv_axi_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TCNT_WIDTH     = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        mem_axi_awvalid,
   input  logic        mem_axi_awready,
   output logic [31:0] mem_axi_awaddr,
   output logic [2:0]  mem_axi_awprot,
   output logic        mem_axi_wvalid,
   input  logic        mem_axi_wready,
   output logic [31:0] mem_axi_wdata,
   output logic [3:0]  mem_axi_wstrb,
   input  logic        mem_axi_bvalid,
   output logic        mem_axi_bready,
   output logic        mem_axi_arvalid,
   input  logic        mem_axi_arready,
   output logic [31:0] mem_axi_araddr,
   output logic [2:0]  mem_axi_arprot,
   input  logic        mem_axi_rvalid,
   output logic        mem_axi_rready,
   input  logic [31:0] mem_axi_rdata,
   output logic        timeout_err
);

   localparam logic [TCNT_WIDTH-1:0] TCNT_LIMIT = TCNT_WIDTH'(TIMEOUT_CYCLES);

   state_e                state_q, state_d;
   logic [31:0]           addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  instr_q, instr_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [TCNT_WIDTH-1:0] tcnt_q, tcnt_d;
   logic                  timeout_q, timeout_d;

   // Every channel output decodes straight from registered state, so reset
   // clears them the instant resetn falls.
   assign mem_axi_awvalid = (state_q == ST_WR) && !aw_done_q;
   assign mem_axi_wvalid  = (state_q == ST_WR) && !w_done_q;
   assign mem_axi_bready  = (state_q == ST_WAIT_B);
   assign mem_axi_arvalid = (state_q == ST_RD);
   assign mem_axi_rready  = (state_q == ST_WAIT_R);
   assign mem_ready       = (state_q == ST_RESP);
   assign mem_rdata       = rdata_q;
   assign mem_axi_awaddr  = addr_q;
   assign mem_axi_awprot  = AXI_PROT_DATA;
   assign mem_axi_wdata   = wdata_q;
   assign mem_axi_wstrb   = wstrb_q;
   assign mem_axi_araddr  = addr_q;
   assign mem_axi_arprot  = read_prot(instr_q);
   assign timeout_err     = timeout_q;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      instr_d   = instr_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      case (state_q)
         ST_IDLE: begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (mem_valid) begin
               addr_d  = mem_addr;
               wdata_d = mem_wdata;
               wstrb_d = mem_wstrb;
               instr_d = mem_instr;
               state_d = (mem_wstrb != MEM_WSTRB_READ) ? ST_WR : ST_RD;
            end
         end
         ST_WR: begin
            // Address and data channels retire independently, possibly together.
            if (mem_axi_awvalid && mem_axi_awready) aw_done_d = 1'b1;
            if (mem_axi_wvalid && mem_axi_wready)   w_done_d  = 1'b1;
            if (aw_done_d && w_done_d)              state_d   = ST_WAIT_B;
         end
         ST_WAIT_B: if (mem_axi_bvalid) state_d = ST_RESP;
         ST_RD:     if (mem_axi_arready) state_d = ST_WAIT_R;
         ST_WAIT_R: begin
            if (mem_axi_rvalid) begin
               rdata_d = mem_axi_rdata;
               state_d = ST_RESP;
            end
         end
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Saturating busy counter; the flag is reported but the transfer carries on.
   always_comb begin
      tcnt_d    = tcnt_q;
      timeout_d = timeout_q;
      if (state_q == ST_IDLE || TIMEOUT_CYCLES == 0) begin
         tcnt_d = '0;
      end else begin
         if (tcnt_q != TCNT_LIMIT) tcnt_d = tcnt_q + TCNT_WIDTH'(1);
         if (tcnt_q == TCNT_LIMIT) timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         instr_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         tcnt_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         instr_q   <= instr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         tcnt_q    <= tcnt_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_picorv_axi_master_bridge.sv
// Randomised bench: delay-configurable AXI4-Lite slave plus a word-array
// reference of memory contents driven from the core-side requests.
module tb_picorv_axi_master_bridge;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        mem_valid, mem_instr, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, timeout_err;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;

   always #5 clk = ~clk;

   picorv_axi_master_bridge #(.TIMEOUT_CYCLES(8), .TCNT_WIDTH(16)) dut (
      .clk(clk), .resetn(resetn),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata),
      .mem_axi_awvalid(awvalid), .mem_axi_awready(awready),
      .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
      .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
      .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
      .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
      .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
      .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
      .mem_axi_rvalid(rvalid), .mem_axi_rready(rready),
      .mem_axi_rdata(rdata), .timeout_err(timeout_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // ---------------- AXI4-Lite slave with per-channel delays ----------------
   int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
   int aw_wait = 0, w_wait = 0, ar_wait = 0, b_cnt = 0, r_cnt = 0;
   int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
   bit [31:0] slv_mem [64];
   logic        aw_got = 1'b0, w_got = 1'b0, bvalid_r = 1'b0, r_pend = 1'b0, rvalid_r = 1'b0;
   logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0, rdata_r = '0;
   logic [3:0]  cap_wstrb = '0;
   logic [2:0]  cap_awprot = '0, cap_arprot = '0;

   assign awready = awvalid && (aw_wait >= aw_delay);
   assign wready  = wvalid && (w_wait >= w_delay);
   assign arready = arvalid && (ar_wait >= ar_delay);
   assign bvalid  = bvalid_r;
   assign rvalid  = rvalid_r;
   assign rdata   = rdata_r;

   always @(posedge clk) begin
      if (!resetn) begin
         aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_cnt <= 0; r_cnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; bvalid_r <= 1'b0; r_pend <= 1'b0; rvalid_r <= 1'b0;
      end else begin
         aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
         w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
         ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
         if (awvalid && awready) begin
            aw_got <= 1'b1; cap_awaddr <= awaddr; cap_awprot <= awprot; n_aw <= n_aw + 1;
         end
         if (wvalid && wready) begin
            w_got <= 1'b1; cap_wdata <= wdata; cap_wstrb <= wstrb; n_w <= n_w + 1;
         end
         if (bvalid_r && bready) begin
            bvalid_r <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0; n_b <= n_b + 1;
            slv_mem[cap_awaddr[7:2]] <= merge(slv_mem[cap_awaddr[7:2]], cap_wdata, cap_wstrb);
         end else if (aw_got && w_got && !bvalid_r) begin
            if (b_cnt >= b_delay) bvalid_r <= 1'b1;
            else b_cnt <= b_cnt + 1;
         end
         if (arvalid && arready) begin
            r_pend <= 1'b1; cap_araddr <= araddr; cap_arprot <= arprot; n_ar <= n_ar + 1;
         end
         if (rvalid_r && rready) begin
            rvalid_r <= 1'b0; r_pend <= 1'b0; r_cnt <= 0; n_r <= n_r + 1;
         end else if (r_pend && !rvalid_r) begin
            if (r_cnt >= r_delay) begin
               rvalid_r <= 1'b1;
               rdata_r  <= slv_mem[cap_araddr[7:2]];
            end else begin
               r_cnt <= r_cnt + 1;
            end
         end
      end
   end

   // Valid must persist with stable payload until its handshake.
   logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
   logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
   logic [3:0]  p_wstrb = '0;
   always @(negedge clk) begin
      if (!resetn) begin
         p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
      end else begin
         if (p_aw) begin
            check("aw_hold", 32'(awvalid), 32'd1);
            check("aw_stable", awaddr, p_awaddr);
         end
         if (p_w) begin
            check("w_hold", 32'(wvalid), 32'd1);
            check("w_stable", {wstrb, wdata[27:0]}, {p_wstrb, p_wdata[27:0]});
         end
         if (p_ar) begin
            check("ar_hold", 32'(arvalid), 32'd1);
            check("ar_stable", araddr, p_araddr);
         end
         p_aw <= awvalid && !awready; p_awaddr <= awaddr;
         p_w  <= wvalid && !wready;   p_wdata <= wdata; p_wstrb <= wstrb;
         p_ar <= arvalid && !arready; p_araddr <= araddr;
      end
   end

   // ---------------- reference model and stimulus ----------------
   bit [31:0]   ref_mem [64];
   logic [31:0] last_rdata = '0;

   // probe: 0 none, 1 slow-awready write, 2 timeout read
   task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic ins, input bit hold, input int probe);
      int c, aw0, w0, b0, ar0, r0;
      bit done;
      logic [31:0] exp_rd;
      aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
      @(negedge clk);
      check("idle_gap", 32'({awvalid, wvalid, arvalid, mem_ready}), 32'd0);
      @(negedge clk);
      if (s != 4'd0) check("lat_wr", 32'({awvalid, wvalid, arvalid}), 32'd6);
      else           check("lat_rd", 32'({awvalid, wvalid, arvalid}), 32'd1);
      c = 1;
      done = mem_ready;
      while (!done && c < 100) begin
         if (probe == 1 && c >= 2 && c <= 4)
            check("slow_aw", 32'({awvalid, wvalid, bready}), 32'd4);
         if (probe == 1 && c == 5) check("slow_aw_waitb", 32'(bready), 32'd1);
         if (probe == 2 && c == 4)  check("tmo_early", 32'(timeout_err), 32'd0);
         if (probe == 2 && c == 15) check("tmo_set", 32'(timeout_err), 32'd1);
         @(negedge clk);
         c++;
         done = mem_ready;
      end
      check("ready_seen", 32'(done), 32'd1);
      if (s != 4'd0) begin
         ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], d, s);
         check("wr_awaddr", cap_awaddr, a);
         check("wr_wdata", cap_wdata, d);
         check("wr_wstrb", 32'(cap_wstrb), 32'(s));
         check("wr_awprot", 32'(cap_awprot), 32'd0);
         check("wr_rdata_keep", mem_rdata, last_rdata);
      end else begin
         exp_rd = ref_mem[a[7:2]];
         check("rd_data", mem_rdata, exp_rd);
         check("rd_araddr", cap_araddr, a);
         check("rd_arprot", 32'(cap_arprot), ins ? 32'd4 : 32'd0);
         last_rdata = exp_rd;
      end
      check("n_aw", 32'(n_aw - aw0), (s != 4'd0) ? 32'd1 : 32'd0);
      check("n_w",  32'(n_w - w0),   (s != 4'd0) ? 32'd1 : 32'd0);
      check("n_b",  32'(n_b - b0),   (s != 4'd0) ? 32'd1 : 32'd0);
      check("n_ar", 32'(n_ar - ar0), (s != 4'd0) ? 32'd0 : 32'd1);
      check("n_r",  32'(n_r - r0),   (s != 4'd0) ? 32'd0 : 32'd1);
      $display("txn %s addr=%08h wdata=%08h wstrb=%h instr=%0d rdata=%08h cycles=%0d",
               (s != 4'd0) ? "WR" : "RD", a, d, s, ins, mem_rdata, c);
      if (!hold) begin
         @(posedge clk); #1;
         mem_valid = 1'b0;
         @(negedge clk);
         check("ready_pulse", 32'(mem_ready), 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rd;
      logic [3:0]  rs;
      mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready, mem_ready, timeout_err}), 32'd0);
      check("rst_rdata", mem_rdata, 32'd0);
      @(posedge clk); #1 resetn = 1'b1;

      // fetch-style read of a known word
      do_req(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 0);
      do_req(32'h0000_0010, 32'h0, 4'h0, 1'b1, 1'b0, 0);
      check("t1_rdata", mem_rdata, 32'hDEAD_BEEF);

      // partial-strobe write into a zeroed word
      do_req(32'h0000_0020, 32'h1122_3344, 4'b0101, 1'b0, 1'b0, 0);
      do_req(32'h0000_0020, 32'h0, 4'h0, 1'b0, 1'b0, 0);
      check("t2_rdata", mem_rdata, 32'h0022_0044);

      // wready three cycles ahead of awready
      aw_delay = 3;
      do_req(32'h0000_0030, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 1);
      aw_delay = 0;

      // back-to-back with mem_valid held
      do_req(32'h0000_0030, 32'h0, 4'h0, 1'b0, 1'b1, 0);
      do_req(32'h0000_0034, 32'hA5A5_5A5A, 4'b1100, 1'b0, 1'b1, 0);
      do_req(32'h0000_0034, 32'h0, 4'h0, 1'b1, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         aw_delay = $urandom_range(0, 1); w_delay = $urandom_range(0, 1);
         ar_delay = $urandom_range(0, 1); b_delay = $urandom_range(0, 1);
         r_delay  = $urandom_range(0, 1);
         ra = 32'($urandom_range(0, 255));
         rd = $urandom;
         rs = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         do_req(ra, rd, rs, 1'($urandom_range(0, 1)), (i != 39) && ($urandom_range(0, 1) == 1), 0);
      end
      aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_delay = 0;
      check("no_tmo_yet", 32'(timeout_err), 32'd0);

      // slave withholds arready for 20 cycles
      ar_delay = 20;
      do_req(32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b0, 2);
      ar_delay = 0;
      repeat (3) @(negedge clk);
      check("tmo_sticky", 32'(timeout_err), 32'd1);

      // reset while waiting for read data
      r_delay = 30;
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_addr = 32'h0000_0020; mem_wstrb = 4'h0; mem_instr = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_rready", 32'(rready), 32'd1);
      #2 resetn = 1'b0;
      #1;
      check("rst_async_outs", 32'({awvalid, wvalid, arvalid, bready, rready, mem_ready, timeout_err}), 32'd0);
      check("rst_async_rdata", mem_rdata, 32'd0);
      mem_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      last_rdata = '0;
      r_delay = 0;
      do_req(32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b0, 0);
      check("post_rst_tmo", 32'(timeout_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
